// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared key codes, opcodes, state enum and instruction layout for the calculator
package calc_pkg;

    localparam logic [3:0] KEY_ADD    = 4'hA;
    localparam logic [3:0] KEY_AND    = 4'hB;
    localparam logic [3:0] KEY_XOR    = 4'hC;
    localparam logic [3:0] KEY_MUL    = 4'hD;
    localparam logic [3:0] KEY_EQUALS = 4'hE;
    localparam logic [3:0] KEY_CLEAR  = 4'hF;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    localparam int OPCODE_W   = 2;
    localparam int OPER_W     = 8;
    localparam int INSTR_W    = OPCODE_W + 2 * OPER_W;
    localparam int OPCODE_LSB = 2 * OPER_W;
    localparam int OPER1_LSB  = OPER_W;
    localparam int OPER2_LSB  = 0;

    typedef enum logic [1:0] {
        ST_OPER1 = 2'd0,
        ST_OPER2 = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'h9;
    endfunction

    function automatic logic is_operator(input logic [3:0] k);
        return (k >= KEY_ADD) && (k <= KEY_MUL);
    endfunction

    function automatic logic [1:0] key_to_opcode(input logic [3:0] k);
        logic [1:0] op;
        case (k)
            KEY_AND: op = OP_AND;
            KEY_XOR: op = OP_XOR;
            KEY_MUL: op = OP_MUL;
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/dec_accum.sv
// rtl/dec_accum.sv - combinational decimal accumulate step: next = acc*10 + d with overflow flag
module dec_accum (
    input  logic [7:0] acc,
    input  logic [3:0] d,
    output logic [7:0] next,
    output logic       ovf
);

    logic [11:0] sum;

    // 255*10 + 9 = 2559 fits in 12 bits, so the overflow test is exact
    always_comb begin
        sum  = ({4'd0, acc} * 12'd10) + {8'd0, d};
        next = sum[7:0];
        ovf  = sum > 12'd255;
    end

endmodule

// File: rtl/calc_entry.sv
// rtl/calc_entry.sv - keypad entry sequencer building ALU instructions; CALC_CHAIN_EN enables result chaining
module calc_entry
    import calc_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 key_valid,
    input  logic [3:0]           key_code,
    input  logic [OPER_W-1:0]    result_in,
    input  logic                 instr_ready,
    output logic [INSTR_W-1:0]   instruction,
    output logic                 instr_valid,
    output logic [OPER_W-1:0]    display_value,
    output logic                 key_error
);

    state_t               state_q, state_d;
    logic [OPER_W-1:0]    acc_q, acc_d;
    logic                 has_digit_q, has_digit_d;
    logic [OPER_W-1:0]    oper1_q, oper1_d;
    logic [OPCODE_W-1:0]  opcode_q, opcode_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic                 key_error_q, key_error_d;

    logic [OPER_W-1:0]    acc_next;
    logic                 acc_ovf;
    logic                 accept;
    logic [OPER_W-1:0]    default_oper1;

    dec_accum u_dec_accum (
        .acc  (acc_q),
        .d    (key_code),
        .next (acc_next),
        .ovf  (acc_ovf)
    );

`ifdef CALC_CHAIN_EN
    logic [OPER_W-1:0] last_result_q, last_result_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) last_result_q <= '0;
        else       last_result_q <= last_result_d;
    end

    always_comb begin
        last_result_d = last_result_q;
        if (accept)
            last_result_d = result_in;
        else if (key_valid && (state_q != ST_ISSUE) && (key_code == KEY_CLEAR))
            last_result_d = '0;
    end

    assign default_oper1 = last_result_q;
`else
    logic unused_result_in;
    assign unused_result_in = ^result_in;
    assign default_oper1    = '0;
`endif

    assign accept = (state_q == ST_ISSUE) && instr_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_OPER1;
            acc_q       <= '0;
            has_digit_q <= 1'b0;
            oper1_q     <= '0;
            opcode_q    <= '0;
            instr_q     <= '0;
            key_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            has_digit_q <= has_digit_d;
            oper1_q     <= oper1_d;
            opcode_q    <= opcode_d;
            instr_q     <= instr_d;
            key_error_q <= key_error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        has_digit_d = has_digit_q;
        oper1_d     = oper1_q;
        opcode_d    = opcode_q;
        instr_d     = instr_q;
        key_error_d = 1'b0;

        case (state_q)
            ST_ISSUE: begin
                // the offered instruction is never aborted; every key here is dropped
                key_error_d = key_valid;
                if (accept) begin
                    state_d     = ST_OPER1;
                    acc_d       = '0;
                    has_digit_d = 1'b0;
                end
            end
            default: begin
                if (key_valid) begin
                    if (is_digit(key_code)) begin
                        if (acc_ovf) begin
                            key_error_d = 1'b1;
                        end else begin
                            acc_d       = acc_next;
                            has_digit_d = 1'b1;
                        end
                    end else if (is_operator(key_code)) begin
                        if (state_q == ST_OPER1) begin
                            oper1_d     = has_digit_q ? acc_q : default_oper1;
                            opcode_d    = key_to_opcode(key_code);
                            acc_d       = '0;
                            has_digit_d = 1'b0;
                            state_d     = ST_OPER2;
                        end else if (has_digit_q) begin
                            key_error_d = 1'b1;
                        end else begin
                            opcode_d = key_to_opcode(key_code);
                        end
                    end else if (key_code == KEY_EQUALS) begin
                        if ((state_q == ST_OPER2) && has_digit_q) begin
                            instr_d = {opcode_q, oper1_q, acc_q};
                            state_d = ST_ISSUE;
                        end else begin
                            key_error_d = 1'b1;
                        end
                    end else begin
                        acc_d       = '0;
                        has_digit_d = 1'b0;
                        oper1_d     = '0;
                        opcode_d    = '0;
                        state_d     = ST_OPER1;
                    end
                end
            end
        endcase
    end

    // oper1 stays on the display until the first oper2 digit arrives
    always_comb begin
        display_value = acc_q;
        if (state_q == ST_ISSUE)
            display_value = instr_q[OPER2_LSB +: OPER_W];
        else if ((state_q == ST_OPER2) && !has_digit_q)
            display_value = oper1_q;
    end

    assign instruction = instr_q;
    assign instr_valid = (state_q == ST_ISSUE);
    assign key_error   = key_error_q;

endmodule

// File: tb/tb_calc_entry.sv
// tb/tb_calc_entry.sv - directed self-checking bench for calc_entry
module tb_calc_entry;
    import calc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [7:0]  result_in;
    logic        instr_ready;
    logic [17:0] instruction;
    logic        instr_valid;
    logic [7:0]  display_value;
    logic        key_error;

    int n_checks = 0;
    int n_fail   = 0;

    calc_entry dut (
        .clk           (clk),
        .reset         (reset),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .result_in     (result_in),
        .instr_ready   (instr_ready),
        .instruction   (instruction),
        .instr_valid   (instr_valid),
        .display_value (display_value),
        .key_error     (key_error)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // drive one key strobe, return on the following falling edge with its effect visible
    task automatic press(input logic [3:0] k, input logic exp_err);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
        check_val($sformatf("key_error_k%0h", k), 32'(key_error), 32'(exp_err));
    endtask

    task automatic press_seq(input logic [3:0] ks[$]);
        foreach (ks[i]) press(ks[i], 1'b0);
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_instr"},  32'(instruction),   32'h0);
        check_val({tag, "_valid"},  32'(instr_valid),   32'h0);
        check_val({tag, "_disp"},   32'(display_value), 32'h0);
        check_val({tag, "_err"},    32'(key_error),     32'h0);
        check_val({tag, "_state"},  32'(dut.state_q),   32'(ST_OPER1));
    endtask

    initial begin
        reset       = 1'b1;
        key_valid   = 1'b0;
        key_code    = 4'h0;
        result_in   = 8'h00;
        instr_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("reset");
        reset = 1'b0;

        // 25 ADD 100 with consumer always ready
        press_seq('{4'h2, 4'h5});
        check_val("t1_disp25", 32'(display_value), 32'd25);
        press(KEY_ADD, 1'b0);
        check_val("t1_disp_oper1", 32'(display_value), 32'd25);
        press_seq('{4'h1, 4'h0, 4'h0});
        check_val("t1_disp100", 32'(display_value), 32'd100);
        press(KEY_EQUALS, 1'b0);
        check_val("t1_valid", 32'(instr_valid), 32'h1);
        check_val("t1_instr", 32'(instruction), 32'h01964);
        @(negedge clk);
        check_val("t1_valid_drop", 32'(instr_valid), 32'h0);
        check_val("t1_state", 32'(dut.state_q), 32'(ST_OPER1));

        // 12 MUL 13 held by backpressure, keys during the wait are dropped
        instr_ready = 1'b0;
        press_seq('{4'h1, 4'h2, KEY_MUL, 4'h1, 4'h3, KEY_EQUALS});
        check_val("t2_valid_c1", 32'(instr_valid), 32'h1);
        check_val("t2_instr_c1", 32'(instruction), 32'h30C0D);
        check_val("t2_disp_issue", 32'(display_value), 32'd13);
        press(4'h7, 1'b1);
        check_val("t2_instr_c2", 32'(instruction), 32'h30C0D);
        press(KEY_CLEAR, 1'b1);
        check_val("t2_instr_c3", 32'(instruction), 32'h30C0D);
        check_val("t2_valid_c3", 32'(instr_valid), 32'h1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_val("t2_valid_wait", 32'(instr_valid), 32'h1);
            check_val("t2_err_wait", 32'(key_error), 32'h0);
            check_val("t2_instr_wait", 32'(instruction), 32'h30C0D);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        check_val("t2_valid_drop", 32'(instr_valid), 32'h0);
        check_val("t2_disp_after", 32'(display_value), 32'd0);

        // range check: 256 rejected, 255 accepted
        press_seq('{4'h2, 4'h5});
        press(4'h6, 1'b1);
        check_val("t3_disp25", 32'(display_value), 32'd25);
        @(negedge clk);
        check_val("t3_err_once", 32'(key_error), 32'h0);
        press(4'h5, 1'b0);
        check_val("t3_disp255", 32'(display_value), 32'd255);
        press(4'h0, 1'b1);
        check_val("t3_disp255_hold", 32'(display_value), 32'd255);
        press(KEY_CLEAR, 1'b0);
        check_val("t3_clear_disp", 32'(display_value), 32'd0);

        // opcode replacement from reset, operator after digit rejected
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        press(KEY_ADD, 1'b0);
        check_val("t4_disp_default", 32'(display_value), 32'd0);
        press(KEY_AND, 1'b0);
        press(4'h3, 1'b0);
        press(KEY_XOR, 1'b1);
        press(KEY_EQUALS, 1'b0);
        check_val("t4_instr", 32'(instruction), 32'h10003);
        @(negedge clk);
        press(KEY_EQUALS, 1'b1);
        press(KEY_EQUALS, 1'b1);

        // asynchronous reset mid-entry
        press_seq('{4'h4, KEY_XOR, 4'h9});
        check_val("t5_disp9", 32'(display_value), 32'd9);
        #2 reset = 1'b1;
        #1;
        check_idle("t5_async");
        @(negedge clk);
        reset = 1'b0;
        result_in = 8'h7D;
        press_seq('{4'h1, KEY_ADD, 4'h1, KEY_EQUALS});
        check_val("t5_instr", 32'(instruction), 32'h00101);

        // reset mid-handshake
        @(negedge clk);
        instr_ready = 1'b0;
        press_seq('{4'h9, KEY_MUL, 4'h9, KEY_EQUALS});
        check_val("t5b_valid", 32'(instr_valid), 32'h1);
        #2 reset = 1'b1;
        #1;
        check_idle("t5b_async");
        @(negedge clk);
        reset = 1'b0;

        // chaining: accept 1 ADD 1 with result 7D, then operator with no digits
        instr_ready = 1'b1;
        result_in   = 8'h7D;
        press_seq('{4'h1, KEY_ADD, 4'h1, KEY_EQUALS});
        @(negedge clk);
        result_in = 8'h00;
        press_seq('{KEY_XOR, 4'h3, KEY_EQUALS});
`ifdef CALC_CHAIN_EN
        check_val("t6_instr_chain", 32'(instruction), 32'h27D03);
`else
        check_val("t6_instr_nochain", 32'(instruction), 32'h20003);
`endif
        @(negedge clk);
        check_val("t6_valid_drop", 32'(instr_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
